// File: rtl/uart_pkg.sv
// Shared constants, state encoding and timing helper for the UART transmit path.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int unsigned clk_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_v2_if.sv
// Core-side write handshake into the UART transmitter.
interface uart_tx_v2_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_tx_DATA_VALID;
    logic                 o_tx_DATA_READY;
    logic [DATA_BITS-1:0] i_tx_DATA;

    modport master (output i_tx_DATA_VALID, output i_tx_DATA, input  o_tx_DATA_READY);
    modport slave  (input  i_tx_DATA_VALID, input  i_tx_DATA, output o_tx_DATA_READY);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and registered full flag.
module sync_fifo #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        count_nxt = count_q;
        if (do_push && !do_pop) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge i_CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_v2.sv
// FIFO-buffered UART transmitter: configurable width, optional parity, 1 or 2 stop bits.
module uart_tx_v2
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              i_CLK,
    input  logic                              i_RESET,
    uart_tx_v2_if.slave                       tx_if,
    input  logic [1:0]                        i_PARITY_MODE,
    input  logic                              i_STOP2,
    output logic                              o_tx_SERIAL,
    output logic                              o_tx_BUSY,
    output logic                              o_tx_DONE,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_FIFO_COUNT
);
    localparam int unsigned CPB   = clk_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd;
    logic                 pop_c;

    tx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_en;
    logic                 stop2;
    logic                 stop_idx;
    logic                 bit_tick;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .push    (tx_if.i_tx_DATA_VALID),
        .pop     (pop_c),
        .wr_data (tx_if.i_tx_DATA),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_FIFO_COUNT)
    );

    assign tx_if.o_tx_DATA_READY = !fifo_full;
    assign bit_tick  = (baud_cnt == CNT_W'(CPB - 1));
    assign pop_c     = (state == ST_IDLE) && !fifo_empty;
    assign o_tx_BUSY = (state != ST_IDLE) || !fifo_empty;

    // Line is registered from the current state, so it trails the FSM by one clock.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            par_en      <= 1'b0;
            stop2       <= 1'b0;
            stop_idx    <= 1'b0;
            o_tx_SERIAL <= 1'b1;
            o_tx_DONE   <= 1'b0;
        end else begin
            o_tx_DONE <= 1'b0;
            baud_cnt  <= (state == ST_IDLE || bit_tick) ? '0 : baud_cnt + CNT_W'(1);

            case (state)
                ST_START:  o_tx_SERIAL <= 1'b0;
                ST_DATA:   o_tx_SERIAL <= shreg[0];
                ST_PARITY: o_tx_SERIAL <= par_bit;
                default:   o_tx_SERIAL <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        shreg   <= fifo_rd;
                        par_en  <= (i_PARITY_MODE == PAR_EVEN) || (i_PARITY_MODE == PAR_ODD);
                        par_bit <= (i_PARITY_MODE == PAR_ODD) ? ~(^fifo_rd) : (^fifo_rd);
                        stop2   <= i_STOP2;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (stop_idx || !stop2) begin
                            o_tx_DONE <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
